// File: rtl/gate_delay_meter_if.sv
// Signal bundle between the delay meter, its requester and the gate under test.
// The master side issues start, plays the gate's return path and reads the results.
interface gate_delay_meter_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             stim;
  logic             resp;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] delay;
  logic             timeout;
  logic             edge_rise;

  modport master (
    output start, resp,
    input  stim, busy, done, delay, timeout, edge_rise
  );

  modport slave (
    input  start, resp,
    output stim, busy, done, delay, timeout, edge_rise
  );
endinterface

// File: rtl/gate_delay_meter.sv
// Drives a toggle into a gate under test and reports its propagation delay in
// clock cycles, after first requiring the gate output to be stable for SETTLE cycles.
module gate_delay_meter #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200,
  parameter int SETTLE  = 4,
  parameter int INVERT  = 1
) (
  input logic              clk,
  input logic              reset,
  gate_delay_meter_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_REPORT
  } state_t;

  localparam logic [CNT_W-1:0] TO_CNT   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] PIPE_LAT = CNT_W'(3);
  localparam logic [4:0]       SETTLE_N = 5'(SETTLE);

  state_t           state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             stim_q, stim_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic             timeout_q, timeout_d;
  logic             edge_q, edge_d;
  logic             r1, r2;

  logic             expected;
  logic             match;
  logic [CNT_W-1:0] cyc_inc;
  logic [4:0]       settle_inc;

  assign expected   = (INVERT != 0) ? ~stim_q : stim_q;
  assign match      = (r2 == expected);
  assign cyc_inc    = cyc_q + 1'b1;
  assign settle_inc = {1'b0, settle_q} + 5'd1;

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    cyc_d     = cyc_q;
    stim_d    = stim_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    delay_d   = delay_q;
    timeout_d = timeout_q;
    edge_d    = edge_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
          cyc_d    = '0;
          busy_d   = 1'b1;
        end
      end

      ST_SETTLE: begin
        cyc_d    = cyc_inc;
        settle_d = match ? settle_inc[3:0] : 4'd0;
        if (match && (settle_inc == SETTLE_N)) begin
          stim_d  = ~stim_q;
          cyc_d   = '0;
          state_d = ST_MEASURE;
        end else if (cyc_inc == TO_CNT) begin
          timeout_d = 1'b1;
          delay_d   = '1;
          done_d    = 1'b1;
          edge_d    = stim_q;
          state_d   = ST_REPORT;
        end
      end

      ST_MEASURE: begin
        cyc_d = cyc_inc;
        if (match) begin
          // Subtract register + synchronizer + sample latency; clamp so an early glitch cannot wrap.
          delay_d   = (cyc_inc < PIPE_LAT) ? '0 : cyc_inc - PIPE_LAT;
          timeout_d = 1'b0;
          done_d    = 1'b1;
          edge_d    = stim_q;
          state_d   = ST_REPORT;
        end else if (cyc_inc == TO_CNT) begin
          timeout_d = 1'b1;
          delay_d   = '1;
          done_d    = 1'b1;
          edge_d    = stim_q;
          state_d   = ST_REPORT;
        end
      end

      ST_REPORT: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      settle_q  <= '0;
      cyc_q     <= '0;
      stim_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      delay_q   <= '0;
      timeout_q <= 1'b0;
      edge_q    <= 1'b0;
      r1        <= 1'b0;
      r2        <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      cyc_q     <= cyc_d;
      stim_q    <= stim_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      delay_q   <= delay_d;
      timeout_q <= timeout_d;
      edge_q    <= edge_d;
      r1        <= bus.resp;
      r2        <= r1;
    end
  end

  assign bus.stim      = stim_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.delay     = delay_q;
  assign bus.timeout   = timeout_q;
  assign bus.edge_rise = edge_q;

endmodule
